// File: rtl/issue_scheduler.sv
// Issue arbiter: picks one ready reservation-station entry per cycle into a single-entry issue register.
// Latency: grant is combinational in the request cycle; fu_valid/fu_sel/fu_rob_idx appear one cycle later.
// Backpressure: while the issue register is held and fu_ready=0, grant stays 0 and the register is frozen.
// Define ISSUE_SCHED_AGE_EN for oldest-first (ROB age) selection; otherwise round-robin selection is built.
module issue_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ROB_IDX_WIDTH-1:0] req_rob_idx,
  input  logic [ROB_IDX_WIDTH-1:0]         rob_head,
  input  logic                             flush,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             fu_valid,
  output logic [$clog2(NUM_REQ)-1:0]       fu_sel,
  output logic [ROB_IDX_WIDTH-1:0]         fu_rob_idx,
  input  logic                             fu_ready,
  output logic [CNT_WIDTH-1:0]             issue_count,
  output logic [CNT_WIDTH-1:0]             stall_count
);

  localparam int SEL_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  state_t           state;
  logic             slot_free;
  logic             arb_en;
  logic [SEL_W-1:0] win;
  logic             found;

  // The slot can take a new instruction if empty or if the FU drains it this cycle.
  assign slot_free = (state == EMPTY) || fu_ready;
  // Reset and flush both suppress arbitration so no entry is consumed and lost.
  assign arb_en    = rst_n && slot_free && !flush && (|req);
  assign fu_valid  = (state == HELD);

`ifdef ISSUE_SCHED_AGE_EN
  logic [ROB_IDX_WIDTH-1:0] age_cur;
  logic [ROB_IDX_WIDTH-1:0] best_age;

  // Oldest-first: smallest modular distance from the ROB head; strict compare keeps the lowest index on ties.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    age_cur  = '0;
    best_age = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        age_cur = req_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] - rob_head;
        if (!found || (age_cur < best_age)) begin
          best_age = age_cur;
          win      = SEL_W'(i);
          found    = 1'b1;
        end
      end
    end
  end
`else
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] cand_idx;
  int               cand;
  logic             unused_rob_head;

  // Age information is not needed when selection is round-robin.
  assign unused_rob_head = ^rob_head;

  // Round-robin: scan from the pointer upward with wrap, first requester wins.
  always_comb begin
    win      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = SEL_W'(cand);
      if (!found && req[cand_idx]) begin
        win   = cand_idx;
        found = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (arb_en) begin
      rr_ptr <= (win == SEL_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

  // One-hot grant only for the winner; arb_en already implies the winner is requesting.
  always_comb begin
    grant = '0;
    if (arb_en && found) begin
      grant[win] = 1'b1;
    end
  end

  // Issue-register FSM: flush empties it, a grant loads it, a drain with no new grant empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      fu_sel     <= '0;
      fu_rob_idx <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (arb_en) begin
      state      <= HELD;
      fu_sel     <= win;
      fu_rob_idx <= req_rob_idx[win*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
    end else if (slot_free) begin
      state <= EMPTY;
    end
  end

  // Performance counters: issues wrap, stalls saturate; flush cycles are not counted and never clear them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count <= '0;
      stall_count <= '0;
    end else if (fu_valid && !flush) begin
      if (fu_ready) begin
        issue_count <= issue_count + 1'b1;
      end else if (stall_count != '1) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios then randomized traffic.
// Expected values come from an integer-arithmetic reference model of the selection and counter rules.
// Built with the same ISSUE_SCHED_AGE_EN setting as the design so the model picks the matching policy.
module tb_issue_scheduler;
  localparam int N    = 4;
  localparam int W    = 5;
  localparam int C    = 4;
  localparam int RMOD = 1 << W;
  localparam int CMOD = 1 << C;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req;
  logic [N*W-1:0]     req_rob_idx;
  logic [W-1:0]       rob_head;
  logic               flush;
  logic [N-1:0]       grant;
  logic               fu_valid;
  logic [1:0]         fu_sel;
  logic [W-1:0]       fu_rob_idx;
  logic               fu_ready;
  logic [C-1:0]       issue_count;
  logic [C-1:0]       stall_count;

  issue_scheduler #(.NUM_REQ(N), .ROB_IDX_WIDTH(W), .CNT_WIDTH(C)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rob_idx(req_rob_idx), .rob_head(rob_head),
    .flush(flush), .grant(grant), .fu_valid(fu_valid), .fu_sel(fu_sel), .fu_rob_idx(fu_rob_idx),
    .fu_ready(fu_ready), .issue_count(issue_count), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // reference model state
  int ridx [N];
  int m_valid, m_sel, m_rob, m_rr, m_issue, m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_in(input logic [3:0] r, input int i0, input int i1, input int i2, input int i3,
                        input int head, input logic rdy, input logic fl);
    ridx[0] = i0; ridx[1] = i1; ridx[2] = i2; ridx[3] = i3;
    req = r;
    for (int i = 0; i < N; i++) req_rob_idx[i*W +: W] = W'(ridx[i]);
    rob_head = W'(head);
    fu_ready = rdy;
    flush = fl;
  endtask

  function automatic int pick();
    int best;
    int best_age;
    int age;
    best = -1;
    best_age = RMOD;
`ifdef ISSUE_SCHED_AGE_EN
    for (int i = 0; i < N; i++) begin
      age = (ridx[i] - int'(rob_head) + RMOD) % RMOD;
      if (req[i] && age < best_age) begin best = i; best_age = age; end
    end
`else
    age = 0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(m_rr + k) % N]) best = (m_rr + k) % N;
    best_age = best_age + age;
`endif
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sel = 0; m_rob = 0; m_rr = 0; m_issue = 0; m_stall = 0;
  endtask

  // one clock cycle: inputs already driven at the falling edge
  task automatic step(input string tag);
    int w;
    logic [3:0] eg;
    bit free;
    #1;
    free = (m_valid == 0) || fu_ready;
    eg = '0;
    w = -1;
    if (free && !flush && req != 0) begin
      w = pick();
      eg[w] = 1'b1;
    end
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    @(posedge clk);
    if (!flush && m_valid == 1) begin
      if (fu_ready) m_issue = (m_issue + 1) % CMOD;
      else if (m_stall < CMOD - 1) m_stall++;
    end
    if (flush) m_valid = 0;
    else if (w >= 0) begin m_valid = 1; m_sel = w; m_rob = ridx[w]; m_rr = (w + 1) % N; end
    else if (free) m_valid = 0;
    @(negedge clk);
    chk({tag, ".fu_valid"}, 32'(fu_valid), 32'(m_valid));
    if (m_valid == 1) begin
      chk({tag, ".fu_sel"}, 32'(fu_sel), 32'(m_sel));
      chk({tag, ".fu_rob_idx"}, 32'(fu_rob_idx), 32'(m_rob));
    end
    chk({tag, ".issue_count"}, 32'(issue_count), 32'(m_issue));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(4'b1111, 1, 2, 3, 4, 0, 1'b1, 1'b0);
    #1;
    model_reset();
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.fu_valid", 32'(fu_valid), 32'd0);
    chk("rst.fu_sel", 32'(fu_sel), 32'd0);
    chk("rst.fu_rob_idx", 32'(fu_rob_idx), 32'd0);
    chk("rst.issue_count", 32'(issue_count), 32'd0);
    chk("rst.stall_count", 32'(stall_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(4'b0000, 0, 0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    set_in(4'b0000, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    do_reset();

    // single request, same-cycle grant, registered outputs next cycle
    set_in(4'b0100, 0, 0, 7, 0, 0, 1'b1, 1'b0);
    step("single");
    chk("single.exact_sel", 32'(fu_sel), 32'd2);
    chk("single.exact_rob", 32'(fu_rob_idx), 32'd7);

    // backpressure: five stall cycles with all entries requesting
    set_in(4'b1111, 3, 4, 5, 6, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("bp");
    chk("bp.stall5", 32'(stall_count), 32'd5);
    chk("bp.sel_stable", 32'(fu_sel), 32'd2);
    fu_ready = 1'b1;
    step("bp_release");
    chk("bp.issue1", 32'(issue_count), 32'd1);

    // flush while held with requests pending
    flush = 1'b1;
    step("flush");
    chk("flush.stall_kept", 32'(stall_count), 32'd5);
    flush = 1'b0;

    // rotation from a fresh pointer
    do_reset();
    set_in(4'b1111, 9, 10, 11, 12, 8, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("rotate");

    // age wrap: head near top, entry1 just past head is oldest
    set_in(4'b0011, 2, 31, 0, 0, 30, 1'b1, 1'b0);
    step("agewrap");

    // stall saturation after 20 blocked cycles
    set_in(4'b0001, 4, 0, 0, 0, 0, 1'b1, 1'b0);
    step("sat_load");
    set_in(4'b1111, 1, 2, 3, 4, 0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("sat");
    chk("sat.max", 32'(stall_count), 32'd15);

    // asynchronous reset in the middle of a held instruction
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.fu_valid", 32'(fu_valid), 32'd0);
    chk("async_rst.grant", 32'(grant), 32'd0);
    chk("async_rst.stall", 32'(stall_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      set_in(4'($urandom_range(0, 15)), $urandom_range(0, RMOD - 1), $urandom_range(0, RMOD - 1),
             $urandom_range(0, RMOD - 1), $urandom_range(0, RMOD - 1), $urandom_range(0, RMOD - 1),
             ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
